// File: rtl/outbound_fifo_rr_scheduler.sv
// Round-robin egress scheduler: grant held per packet; dvld in IDLE -> pop next cycle -> eg_valid the cycle after.
// Backpressure: never pops while eg_valid=1 & eg_ready=0; the egress register holds until accepted.
module outbound_fifo_rr_scheduler #(
    parameter int NUM_Q         = 4,
    parameter int RWIDTH        = 10,
    parameter int MAX_PKT_WORDS = 64,
    localparam int GW           = $clog2(NUM_Q),
    localparam int CW           = $clog2(MAX_PKT_WORDS + 1)
) (
    input  logic                    pos_rclk,
    input  logic                    aresetn_rclk,
    input  logic                    sresetn_rclk,
    input  logic [NUM_Q-1:0]        q_dvld,
    input  logic [NUM_Q*RWIDTH-1:0] q_dout,
    output logic [NUM_Q-1:0]        q_rd_en,
    output logic                    eg_valid,
    output logic [RWIDTH-1:0]       eg_data,
    input  logic                    eg_ready,
    output logic [GW-1:0]           grant_id,
    output logic                    busy,
    output logic                    timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     grant_nxt, winner;
    logic [GW:0]       scan_idx;
    logic [CW-1:0]     count, count_nxt, count_inc;
    logic [RWIDTH-1:0] head;
    logic              head_vld;
    logic              pop;
    logic              eg_valid_nxt;
    logic [RWIDTH-1:0] eg_data_nxt;
    logic              timeout_nxt;

    assign busy      = (state == XFER);
    assign count_inc = count + 1'b1;

    // Scan from the far end so the nearest requester after grant_id wins.
    always_comb begin
        winner   = grant_id;
        scan_idx = '0;
        for (int k = NUM_Q; k >= 1; k--) begin
            scan_idx = {1'b0, grant_id} + (GW+1)'(k);
            if (scan_idx >= (GW+1)'(NUM_Q))
                scan_idx = scan_idx - (GW+1)'(NUM_Q);
            if (q_dvld[scan_idx[GW-1:0]])
                winner = scan_idx[GW-1:0];
        end
    end

    always_comb begin
        head     = '0;
        head_vld = 1'b0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (grant_id == GW'(i)) begin
                head     = q_dout[i*RWIDTH +: RWIDTH];
                head_vld = q_dvld[i];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_id;
        count_nxt    = count;
        eg_valid_nxt = eg_valid & ~eg_ready;
        eg_data_nxt  = eg_data;
        timeout_nxt  = 1'b0;
        pop          = 1'b0;
        q_rd_en      = '0;
        case (state)
            IDLE: begin
                if (|q_dvld) begin
                    grant_nxt = winner;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                // Gated by the sync reset so a FIFO is never popped into a word that gets discarded.
                pop               = head_vld & (~eg_valid | eg_ready) & sresetn_rclk;
                q_rd_en[grant_id] = pop;
                if (pop) begin
                    eg_valid_nxt = 1'b1;
                    eg_data_nxt  = head;
                    count_nxt    = count_inc;
                    if (head[RWIDTH-1]) begin
                        state_nxt = IDLE;
                        count_nxt = '0;
                    end else if (count_inc == CW'(MAX_PKT_WORDS)) begin
                        state_nxt   = IDLE;
                        count_nxt   = '0;
                        timeout_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
        if (!aresetn_rclk) begin
            state       <= IDLE;
            grant_id    <= GW'(NUM_Q - 1);
            count       <= '0;
            eg_valid    <= 1'b0;
            eg_data     <= '0;
            timeout_err <= 1'b0;
        end else if (!sresetn_rclk) begin
            state       <= IDLE;
            grant_id    <= GW'(NUM_Q - 1);
            count       <= '0;
            eg_valid    <= 1'b0;
            eg_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant_id    <= grant_nxt;
            count       <= count_nxt;
            eg_valid    <= eg_valid_nxt;
            eg_data     <= eg_data_nxt;
            timeout_err <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_outbound_fifo_rr_scheduler.sv
// Bench for outbound_fifo_rr_scheduler: FWFT FIFO models feed two instances (normal watchdog and a
// 4-word watchdog); egress words are scoreboarded against the order the round-robin rules predict.
module tb_outbound_fifo_rr_scheduler;

    logic        clk;
    logic        aresetn;
    logic        sresetn;
    logic        eg_ready;

    logic [3:0]  dvld_a, rd_a, dvld_b, rd_b;
    logic [39:0] dout_a, dout_b;
    logic        egv_a, egv_b, busy_a, busy_b, to_a, to_b;
    logic [9:0]  egd_a, egd_b;
    logic [1:0]  grant_a, grant_b;

    outbound_fifo_rr_scheduler #(.NUM_Q(4), .RWIDTH(10), .MAX_PKT_WORDS(64)) dut (
        .pos_rclk(clk), .aresetn_rclk(aresetn), .sresetn_rclk(sresetn),
        .q_dvld(dvld_a), .q_dout(dout_a), .q_rd_en(rd_a),
        .eg_valid(egv_a), .eg_data(egd_a), .eg_ready(eg_ready),
        .grant_id(grant_a), .busy(busy_a), .timeout_err(to_a)
    );

    outbound_fifo_rr_scheduler #(.NUM_Q(4), .RWIDTH(10), .MAX_PKT_WORDS(4)) dut_wd (
        .pos_rclk(clk), .aresetn_rclk(aresetn), .sresetn_rclk(sresetn),
        .q_dvld(dvld_b), .q_dout(dout_b), .q_rd_en(rd_b),
        .eg_valid(egv_b), .eg_data(egd_b), .eg_ready(eg_ready),
        .grant_id(grant_b), .busy(busy_b), .timeout_err(to_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] exp_grant;
    } vec_t;

    int         tot;
    int         pass_cnt;
    int         cyc;
    int         serial;
    logic [9:0] fq[8][$];
    logic [9:0] exq[2][$];
    logic [9:0] last_load[$];
    bit         hold_v[2];
    logic [9:0] hold_dat[2];
    int         rx_cnt[2];
    int         to_cnt[2];
    logic [9:0] to_word;
    bit         pbusy_a, rise_a;
    logic [3:0] last_rd_a;
    bit         t1_rec;
    int         stamp[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            dvld_a[i]          = fq[i].size() != 0;
            dout_a[i*10 +: 10] = dvld_a[i] ? fq[i][0] : 10'h0;
            dvld_b[i]          = fq[4+i].size() != 0;
            dout_b[i*10 +: 10] = dvld_b[i] ? fq[4+i][0] : 10'h0;
        end
    endtask

    // Word layout: {last, source id, serial}.
    task automatic load(int d, int q, int n, bit last, bit push);
        logic [9:0] w;
        last_load.delete();
        for (int k = 0; k < n; k++) begin
            w = {last && (k == n - 1), 3'(q), 6'(serial)};
            serial++;
            fq[d*4+q].push_back(w);
            last_load.push_back(w);
            if (push) exq[d].push_back(w);
        end
        refresh();
    endtask

    task automatic observe(int d, logic [3:0] rd, logic [3:0] dv, logic v, logic [9:0] dat, logic to);
        if (rd != 4'b0)
            chk("pop_legal", {26'b0, rd & ~dv, $onehot(rd), v & ~eg_ready}, 32'h2);
        if (hold_v[d])
            chk("stall_hold", {21'b0, v, dat}, {21'b0, 1'b1, hold_dat[d]});
        hold_v[d]   = v & ~eg_ready;
        hold_dat[d] = dat;
        if (to) begin
            to_cnt[d]++;
            if (d == 1) chk("timeout_word", {22'b0, dat}, {22'b0, to_word});
        end
        if (v && eg_ready) begin
            rx_cnt[d]++;
            if (d == 0 && t1_rec) stamp.push_back(cyc);
            if (exq[d].size() == 0) begin
                tot++;
                $display("FAIL unexpected_word dut%0d: got %h, expected no word", d, dat);
            end else begin
                chk("egress_word", {22'b0, dat}, {22'b0, exq[d].pop_front()});
            end
        end
    endtask

    task automatic cycle();
        logic [3:0] ra, rb;
        @(negedge clk);
        cyc++;
        ra        = rd_a;
        rb        = rd_b;
        last_rd_a = ra;
        observe(0, ra, dvld_a, egv_a, egd_a, to_a);
        observe(1, rb, dvld_b, egv_b, egd_b, to_b);
        rise_a  = busy_a & ~pbusy_a;
        pbusy_a = busy_a;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ra[i] && fq[i].size() != 0)   void'(fq[i].pop_front());
            if (rb[i] && fq[4+i].size() != 0) void'(fq[4+i].pop_front());
        end
        refresh();
    endtask

    task automatic drain(int d, int lim);
        for (int t = 0; t < lim && exq[d].size() != 0; t++) cycle();
        chk("drain", exq[d].size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t       vecs[8];
        logic [9:0] word_of[4];
        logic [9:0] q0w[$];
        logic [9:0] q3w[$];
        bit         got;
        int         r0, t0;

        vecs[0] = '{4'b0101, 2'd0};
        vecs[1] = '{4'b1000, 2'd2};
        vecs[2] = '{4'b0010, 2'd3};
        vecs[3] = '{4'b0000, 2'd1};
        vecs[4] = '{4'b1001, 2'd3};
        vecs[5] = '{4'b0000, 2'd0};
        vecs[6] = '{4'b0010, 2'd1};
        vecs[7] = '{4'b0010, 2'd1};

        tot = 0; pass_cnt = 0; cyc = 0; serial = 0;
        pbusy_a = 0; rise_a = 0; t1_rec = 0; to_word = '0; last_rd_a = '0;
        hold_v = '{0, 0}; rx_cnt = '{0, 0}; to_cnt = '{0, 0};
        aresetn = 1'b0; sresetn = 1'b1; eg_ready = 1'b1;
        refresh();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant_a", grant_a, 3);
        chk("rst_grant_b", grant_b, 3);
        chk("rst_outs_a", {egv_a, busy_a, to_a, rd_a, egd_a}, 0);
        chk("rst_outs_b", {egv_b, busy_b, to_b, rd_b, egd_b}, 0);
        aresetn = 1'b1;

        // T1: four 3-word packets, full rate, one arbitration bubble between packets
        t1_rec = 1;
        for (int q = 0; q < 4; q++) load(0, q, 3, 1, 1);
        t0 = cyc + 1;
        drain(0, 60);
        t1_rec = 0;
        chk("t1_words", stamp.size(), 12);
        if (stamp.size() == 12) begin
            chk("t1_latency", stamp[0] - t0, 2);
            chk("t1_b2b", stamp[1] - stamp[0], 1);
            for (int p = 0; p < 3; p++)
                chk("t1_bubble", stamp[3*p+3] - stamp[3*p+2], 2);
        end

        // Arbitration table: new requesters added as each grant is seen
        for (int v = 0; v < 8; v++) begin
            for (int q = 0; q < 4; q++) begin
                if (vecs[v].mask[q] && fq[q].size() == 0) begin
                    load(0, q, 1, 1, 0);
                    word_of[q] = last_load[0];
                end
            end
            got = 0;
            for (int t = 0; t < 20 && !got; t++) begin
                cycle();
                got = rise_a;
            end
            chk("tbl_grant_seen", got, 1);
            if (got) begin
                chk("tbl_grant", grant_a, vecs[v].exp_grant);
                exq[0].push_back(word_of[vecs[v].exp_grant]);
            end
        end
        drain(0, 20);

        // T2: 5-word packet from Q2 with eg_ready toggling
        r0 = rx_cnt[0];
        load(0, 2, 5, 1, 1);
        for (int t = 0; t < 80 && exq[0].size() != 0; t++) begin
            cycle();
            eg_ready = ~eg_ready;
        end
        eg_ready = 1'b1;
        chk("t2_drain", exq[0].size(), 0);
        chk("t2_count", rx_cnt[0] - r0, 5);
        cycle();

        // T3: Q1 stalls mid-packet while Q0 and Q3 wait
        load(0, 1, 2, 0, 1);
        for (int t = 0; t < 20 && fq[1].size() != 0; t++) cycle();
        load(0, 0, 2, 1, 0);
        q0w = last_load;
        load(0, 3, 2, 1, 0);
        q3w = last_load;
        repeat (10) cycle();
        chk("t3_grant", grant_a, 1);
        chk("t3_busy", busy_a, 1);
        chk("t3_quiet", {egv_a, rd_a}, 0);
        load(0, 1, 2, 1, 1);
        foreach (q3w[i]) exq[0].push_back(q3w[i]);
        foreach (q0w[i]) exq[0].push_back(q0w[i]);
        drain(0, 40);

        // T4: watchdog instance, 6 unterminated words from Q0, Q2 waiting
        load(1, 0, 6, 0, 0);
        q0w = last_load;
        load(1, 2, 1, 1, 0);
        for (int i = 0; i < 4; i++) exq[1].push_back(q0w[i]);
        exq[1].push_back(last_load[0]);
        exq[1].push_back(q0w[4]);
        exq[1].push_back(q0w[5]);
        to_word = q0w[3];
        drain(1, 40);
        repeat (3) cycle();
        chk("t4_pulses", to_cnt[1], 1);
        chk("t4_hold_q0", {busy_b, grant_b}, {1'b1, 2'd0});

        // T5: async reset mid-packet, then Q3 alone
        load(0, 2, 4, 1, 1);
        r0 = rx_cnt[0];
        for (int t = 0; t < 20 && rx_cnt[0] - r0 < 2; t++) cycle();
        aresetn = 1'b0;
        #1;
        chk("t5_rst_outs", {egv_a, busy_a, to_a, rd_a, egd_a}, 0);
        chk("t5_rst_grant", grant_a, 3);
        chk("t5_rst_b", {busy_b, grant_b}, {1'b0, 2'd3});
        for (int i = 0; i < 8; i++) fq[i].delete();
        exq[0].delete();
        exq[1].delete();
        hold_v = '{0, 0};
        load(0, 3, 1, 1, 1);
        repeat (2) begin
            cycle();
            chk("t5_no_pop_in_reset", {last_rd_a, rd_a}, 0);
        end
        aresetn = 1'b1;
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            cycle();
            got = rise_a;
        end
        chk("t5_grant_seen", got, 1);
        chk("t5_first_grant", grant_a, 3);
        drain(0, 10);

        // Synchronous reset mid-packet
        load(0, 1, 3, 1, 1);
        r0 = rx_cnt[0];
        for (int t = 0; t < 20 && rx_cnt[0] == r0; t++) cycle();
        sresetn = 1'b0;
        cycle();
        chk("srst_no_pop", last_rd_a, 0);
        chk("srst_outs", {egv_a, busy_a, grant_a}, {1'b0, 1'b0, 2'd3});
        sresetn = 1'b1;
        fq[1].delete();
        exq[0].delete();
        refresh();
        repeat (3) cycle();

        chk("no_timeout_a", to_cnt[0], 0);
        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end

endmodule
